// File: rtl/lm_sm_pkg.sv
// rtl/lm_sm_pkg.sv - shared types and constants for the LM/SM sequencer
package lm_sm_pkg;

  localparam int ADDR_W = 16;
  localparam int MASK_W = 8;
  localparam int RIDX_W = 3;

  localparam logic OP_LM = 1'b0;
  localparam logic OP_SM = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/lm_sm_sequencer_prienc.sv
// rtl/lm_sm_sequencer_prienc.sv - lowest-set-bit priority encoder
//
// Ports:
//   mask   in   MASK_W  bit vector to search
//   idx    out  RIDX_W  index of the lowest set bit (0 when mask is zero)
//   valid  out  1       mask has at least one bit set
module lsb_prienc
  import lm_sm_pkg::*;
#(
  parameter int PMASK_W = MASK_W,
  parameter int PRIDX_W = RIDX_W
) (
  input  logic [PMASK_W-1:0] mask,
  output logic [PRIDX_W-1:0] idx,
  output logic               valid
);

  // Scan from the top down so the last match written is the lowest bit.
  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = PMASK_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = PRIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM multi-cycle register/memory transfer sequencer
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               LM/SM valid in RR stage; is_store, imm_mask, base_addr sampled with it
//   stage_ready         MEM/WB accepts the presented transfer this cycle
//   flush               synchronous abort of any sequence in progress
//   busy, stall_fetch   sequencer active / freeze front end
//   mem_valid, mem_wr, rf_wr, reg_addr, mem_addr   current transfer
//   is_one_hot_or_zero  remaining mask has at most one bit set
//   done                one-cycle pulse after the last accepted transfer
module lm_sm_sequencer
  import lm_sm_pkg::*;
#(
  parameter int P_ADDR_W = ADDR_W,
  parameter int P_MASK_W = MASK_W,
  parameter int P_RIDX_W = RIDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_store,
  input  logic [P_MASK_W-1:0] imm_mask,
  input  logic [P_ADDR_W-1:0] base_addr,
  input  logic                stage_ready,
  input  logic                flush,
  output logic                busy,
  output logic                stall_fetch,
  output logic                mem_valid,
  output logic                mem_wr,
  output logic                rf_wr,
  output logic [P_RIDX_W-1:0] reg_addr,
  output logic [P_ADDR_W-1:0] mem_addr,
  output logic                is_one_hot_or_zero,
  output logic                done
);

  state_t              state_q, state_d;
  logic [P_MASK_W-1:0] mask_q;
  logic [P_ADDR_W-1:0] addr_q;
  logic                op_q;
  logic                done_q;

  logic [P_RIDX_W-1:0] cur_idx;
  logic                cur_valid;
  logic [P_MASK_W-1:0] cur_bit;
  logic [P_MASK_W-1:0] mask_clr;
  logic                in_xfer;
  logic                accept;
  logic                take_start;

  lsb_prienc #(
    .PMASK_W(P_MASK_W),
    .PRIDX_W(P_RIDX_W)
  ) u_prienc (
    .mask (mask_q),
    .idx  (cur_idx),
    .valid(cur_valid)
  );

  assign in_xfer    = (state_q == XFER);
  assign cur_bit    = P_MASK_W'(1) << cur_idx;
  assign mask_clr   = mask_q & ~cur_bit;
  // A transfer presented alongside flush is squashed, never counted.
  assign accept     = in_xfer & cur_valid & stage_ready & ~flush;
  assign take_start = (state_q == IDLE) & start & ~flush;

  always_comb begin
    state_d            = state_q;
    busy               = 1'b0;
    stall_fetch        = 1'b0;
    mem_valid          = 1'b0;
    mem_wr             = 1'b0;
    rf_wr              = 1'b0;
    reg_addr           = '0;
    mem_addr           = '0;
    is_one_hot_or_zero = ((mask_q & (mask_q - P_MASK_W'(1))) == '0);
    done               = done_q;

    case (state_q)
      IDLE: begin
        // Same-cycle freeze so the instruction behind LM/SM cannot advance.
        stall_fetch = take_start & (imm_mask != '0);
        if (take_start && (imm_mask != '0)) begin
          state_d = XFER;
        end
      end
      XFER: begin
        busy        = 1'b1;
        stall_fetch = 1'b1;
        mem_valid   = cur_valid;
        reg_addr    = cur_idx;
        mem_addr    = addr_q;
        // mem_wr stays up through backpressure; memory qualifies with stage_ready.
        mem_wr      = (op_q == OP_SM);
        rf_wr       = (op_q == OP_LM) & stage_ready & ~flush;
        if (flush) begin
          state_d = IDLE;
        end else if (accept && (mask_clr == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      op_q    <= OP_LM;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (flush) begin
        mask_q <= '0;
      end else if (take_start) begin
        mask_q <= imm_mask;
        addr_q <= base_addr;
        op_q   <= is_store;
        // Empty mask: nothing to transfer, complete immediately.
        done_q <= (imm_mask == '0);
      end else if (accept) begin
        mask_q <= mask_clr;
        addr_q <= addr_q + P_ADDR_W'(1);
        done_q <= (mask_clr == '0);
      end
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - scoreboard testbench for lm_sm_sequencer
module tb_lm_sm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [7:0]  imm_mask;
  logic [15:0] base_addr;
  logic        stage_ready;
  logic        flush;
  logic        busy;
  logic        stall_fetch;
  logic        mem_valid;
  logic        mem_wr;
  logic        rf_wr;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;
  logic        is_one_hot_or_zero;
  logic        done;

  lm_sm_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .is_store          (is_store),
    .imm_mask          (imm_mask),
    .base_addr         (base_addr),
    .stage_ready       (stage_ready),
    .flush             (flush),
    .busy              (busy),
    .stall_fetch       (stall_fetch),
    .mem_valid         (mem_valid),
    .mem_wr            (mem_wr),
    .rf_wr             (rf_wr),
    .reg_addr          (reg_addr),
    .mem_addr          (mem_addr),
    .is_one_hot_or_zero(is_one_hot_or_zero),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int unsigned ridx;
    logic [15:0] addr;
    bit          op;
    bit          last;
  } item_t;

  item_t q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected transfer list of one LM/SM, derived from the mask, then a done marker.
  task automatic push_instr(input bit op, input logic [7:0] m, input logic [15:0] b);
    item_t e;
    int    k   = 0;
    int    rem = $countones(m);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.is_done = 1'b0;
        e.ridx    = i;
        e.addr    = b + 16'(k);
        e.op      = op;
        e.last    = (rem == 1);
        q.push_back(e);
        k++;
        rem--;
      end
    end
    e.is_done = 1'b1;
    e.ridx    = 0;
    e.addr    = '0;
    e.op      = op;
    e.last    = 1'b0;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy",        32'(busy),               32'd0);
    chk("rst_stall_fetch", 32'(stall_fetch),        32'd0);
    chk("rst_mem_valid",   32'(mem_valid),          32'd0);
    chk("rst_mem_wr",      32'(mem_wr),             32'd0);
    chk("rst_rf_wr",       32'(rf_wr),              32'd0);
    chk("rst_reg_addr",    32'(reg_addr),           32'd0);
    chk("rst_mem_addr",    32'(mem_addr),           32'd0);
    chk("rst_one_hot",     32'(is_one_hot_or_zero), 32'd1);
    chk("rst_done",        32'(done),               32'd0);
  endtask

  // rmode: 0 ready always high, 1 random, 2 low for first three cycles
  task automatic run_instr(input bit op, input logic [7:0] m, input logic [15:0] b,
                           input int rmode, input int flush_cyc);
    int cyc = 0;
    push_instr(op, m, b);
    start       = 1'b1;
    is_store    = op;
    imm_mask    = m;
    base_addr   = b;
    flush       = 1'b0;
    stage_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start     = 1'b0;
    is_store  = 1'($urandom_range(0, 1));
    imm_mask  = 8'($urandom);
    base_addr = 16'($urandom);
    while ((q.size() != 0 || busy) && cyc < 200) begin
      case (rmode)
        0:       stage_ready = 1'b1;
        2:       stage_ready = (cyc >= 3);
        default: stage_ready = ($urandom_range(0, 3) != 0);
      endcase
      flush = (cyc == flush_cyc);
      @(posedge clk); #1;
      cyc++;
    end
    flush = 1'b0;
    n_cmp++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL timeout: sequence still pending after %0d cycles (mask 0x%0h)", cyc, m);
    end
  endtask

  // Monitor / scoreboard
  bit    in_flight = 1'b0;
  bit    due       = 1'b0;
  bit    was;
  bit    new_start;
  item_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      in_flight = 1'b0;
      due       = 1'b0;
    end else begin
      was       = in_flight;
      new_start = start && !flush && (imm_mask != 8'h00) && !was;
      chk("busy",        32'(busy),        32'(was));
      chk("mem_valid",   32'(mem_valid),   32'(was));
      chk("stall_fetch", 32'(stall_fetch), 32'(was | new_start));
      chk("done",        32'(done),        32'(due));
      if (due) begin
        if (q.size() > 0) q.pop_front();
        due = 1'b0;
      end
      if (was) begin
        if (q.size() == 0 || q[0].is_done) begin
          n_cmp++;
          n_fail++;
          $display("FAIL xfer_underrun: transfer presented with reg_addr %0d but none expected", reg_addr);
          in_flight = 1'b0;
        end else begin
          cur = q[0];
          chk("reg_addr", 32'(reg_addr),           32'(cur.ridx));
          chk("mem_addr", 32'(mem_addr),           32'(cur.addr));
          chk("mem_wr",   32'(mem_wr),             32'(cur.op));
          chk("one_hot",  32'(is_one_hot_or_zero), 32'(cur.last));
          if (!flush) chk("rf_wr", 32'(rf_wr), 32'(!cur.op && stage_ready));
          if (flush) begin
            q.delete();
            in_flight = 1'b0;
          end else if (stage_ready) begin
            void'(q.pop_front());
            if (cur.last) in_flight = 1'b0;
          end
        end
      end else begin
        chk("one_hot_idle", 32'(is_one_hot_or_zero), 32'd1);
        if (flush) q.delete();
      end
      if (new_start) in_flight = 1'b1;
      due = !in_flight && (q.size() > 0) && q[0].is_done;
    end
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    is_store    = 1'b0;
    imm_mask    = 8'h00;
    base_addr   = 16'h0000;
    stage_ready = 1'b0;
    flush       = 1'b0;
    #2;
    check_reset_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(1'b0, 8'hA5, 16'h0040, 0, -1);
    run_instr(1'b1, 8'h80, 16'hFFFF, 0, -1);
    run_instr(1'b0, 8'h00, 16'h1234, 0, -1);
    run_instr(1'b1, 8'h03, 16'h0100, 2, -1);
    run_instr(1'b0, 8'hFF, 16'h0200, 0, 2);

    // flush and start together: nothing latched, no stall
    start    = 1'b1;
    flush    = 1'b1;
    is_store = 1'b0;
    imm_mask = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // asynchronous reset in the middle of a sequence
    push_instr(1'b0, 8'hFF, 16'h0300);
    start       = 1'b1;
    is_store    = 1'b0;
    imm_mask    = 8'hFF;
    base_addr   = 16'h0300;
    stage_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(1'b1, 8'h5A, 16'hFFFE, 1, -1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] m;
      int         sel;
      int         fc;
      sel = $urandom_range(0, 9);
      if (sel == 0)      m = 8'h00;
      else if (sel <= 2) m = 8'(1) << $urandom_range(0, 7);
      else               m = 8'($urandom);
      fc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(1'($urandom_range(0, 1)), m, 16'($urandom), 1, fc);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
